seg_display_ctrl: RTL and testbench
===================================

// Module: seg_display_ctrl
// PURPOSE
//   Parametrised multi-digit 7-segment display controller for the timer front end.
//   - Registers an N-digit hex/BCD value and drives one 7-segment field per digit.
//   - Adds a power-on lamp test, leading-zero blanking, global blanking and per-digit blink.
//   - Sits between the timer counter datapath and the board HEX display pins.
// PARAMETERS
//   NUM_DIGITS   5    number of digits, >=1; digit 0 is the least significant
//   ACTIVE_LOW   1    1: segment on = 0 (board default); 0: segment on = 1
//   BLINK_DIV    4    clk_i cycles per blink half-period, >=2
//   LAMP_CYCLES  3    clk_i cycles of all-segments-on after reset; 0 skips the lamp test
// PORTS
//   clk_i         in   1             single clock, rising edge
//   rst_i         in   1             asynchronous reset, active-high
//   load_i        in   1             capture value_i on this edge
//   value_i       in   4*NUM_DIGITS  nibble d at [4d+3:4d]
//   lzb_en_i      in   1             enable leading-zero blanking
//   blank_i       in   1             blank every digit
//   blink_mask_i  in   NUM_DIGITS    bit d=1: digit d blinks
//   disp_o        out  7*NUM_DIGITS  segments 6..0 of digit d at [7d+6:7d]; registered
//   lamp_o        out  1             1 while in state LAMP
//   blink_phase_o out  1             1 = blink-visible half-period
// BEHAVIOUR
//   Reset (async, immediate, including mid-operation):
//   - disp_o = all segments off.
//   - val_q = 0; blink counter = 0; blink_phase_o = 1; lamp counter = 0.
//   - State = LAMP if LAMP_CYCLES>0, else RUN; lamp_o follows the state.
//   Encoding per nibble, segment order 6543210, shown active-high (inverted when ACTIVE_LOW=1):
//     0:0111111 1:0000110 2:1011011 3:1001111 4:1100110 5:1101101 6:1111101 7:0000111
//     8:1111111 9:1100111 A:1110111 b:1111100 C:0111001 d:1011110 E:1111001 F:1110001
//     Blank = all segments off; all-on = every segment on.
//   Value register: val_q <= value_i on any edge with load_i=1, in both states; otherwise holds.
//   Latency: a load sampled at edge N shows on disp_o after edge N+1.
//   FSM:
//   - LAMP: disp_o <= all-on every edge; lamp counter increments.
//     At counter = LAMP_CYCLES-1, go to RUN; disp_o holds all-on for exactly LAMP_CYCLES cycles.
//   - RUN: terminal until the next reset; disp_o <= per-digit result below.
//   Blink:
//   - Counter runs 0..BLINK_DIV-1 in both states; it does not saturate.
//   - On the edge where it wraps to 0, blink_phase_o toggles.
//   Per-digit priority in RUN, highest first:
//   1. blank_i=1 -> blank.
//   2. blink_mask_i[d]=1 and blink_phase_o=0 -> blank.
//   3. lzb_en_i=1, d>0, and nibbles d..NUM_DIGITS-1 of val_q are all 0 -> blank.
//      Digit 0 is never blanked by LZB, so value 0 shows a single "0".
//   4. Otherwise decode nibble d of val_q.
//   Sampling: blank_i, lzb_en_i and blink_mask_i are sampled each edge, 1-cycle latency, no capture.
//   Simultaneous events:
//   - load_i with blank_i: the value is stored and hidden; it shows once blank_i drops.
//   - LZB and blink apply together; either one blanks the digit.
//   LAMP has priority over every input.
//   Widths: counters are $clog2-sized with a minimum of 1 bit.
//   No combinational path from any input to disp_o.
// TESTING  (NUM_DIGITS=5, ACTIVE_LOW=1, BLINK_DIV=4, LAMP_CYCLES=3)
//   1. Release reset: disp_o=35'h0 and lamp_o=1 for 3 cycles, then lamp_o=0.
//      With no load, RUN shows 5 x 7'b1000000 (all "0").
//   2. load_i with value_i=20'h1A2F3: one edge later digits 4..0 show
//      7'b1111001, 7'b0001000, 7'b0100100, 7'b0001110, 7'b0110000.
//   3. lzb_en_i=1, value 20'h00405: digits 4,3 blank (7'h7F); digits 2..0 show "4","0","5".
//      Value 20'h00000: only digit 0 shows "0".
//   4. blink_mask_i=5'b00001: digit 0 alternates decoded/7'h7F every 4 cycles;
//      blink_phase_o toggles every 4 cycles; other digits are steady.
//   5. blank_i=1 while load_i loads 20'h12345: all digits 7'h7F.
//      After blank_i drops, "12345" appears one cycle later.
//   6. Assert rst_i mid-RUN with a value shown: disp_o goes to 7'h7F per digit immediately.
//      After release, the lamp test repeats and the display shows 0.

Source files
------------

// File: rtl/seg_display_ctrl.sv
// -----------------------------------------------------------------------------
// seg_display_ctrl
//   Multi-digit 7-segment display controller for the timer front end.
//   Holds an N-digit hex/BCD value and drives one registered 7-segment field
//   per digit. After reset, a lamp test lights every segment for LAMP_CYCLES
//   cycles. It then enters RUN, which applies global blanking, per-digit blink
//   and leading-zero blanking on top of the hex decode.
//
// Ports
//   clk_i          in   rising-edge clock
//   rst_i          in   asynchronous reset, active-high
//   load_i         in   capture value_i on this edge
//   value_i        in   4*NUM_DIGITS, nibble d at [4d+3:4d]
//   lzb_en_i       in   enable leading-zero blanking
//   blank_i        in   blank every digit
//   blink_mask_i   in   NUM_DIGITS, bit d=1 makes digit d blink
//   disp_o         out  7*NUM_DIGITS, segments 6..0 of digit d at [7d+6:7d]
//   lamp_o         out  high while the lamp test runs
//   blink_phase_o  out  1 = blink-visible half-period
// -----------------------------------------------------------------------------
module seg_display_ctrl #(
   parameter int NUM_DIGITS  = 5,
   parameter int ACTIVE_LOW  = 1,
   parameter int BLINK_DIV   = 4,
   parameter int LAMP_CYCLES = 3
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      load_i,
   input  logic [4*NUM_DIGITS-1:0]   value_i,
   input  logic                      lzb_en_i,
   input  logic                      blank_i,
   input  logic [NUM_DIGITS-1:0]     blink_mask_i,
   output logic [7*NUM_DIGITS-1:0]   disp_o,
   output logic                      lamp_o,
   output logic                      blink_phase_o
);

   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam int LAMP_W  = (LAMP_CYCLES > 1) ? $clog2(LAMP_CYCLES) : 1;

   // Physical levels for one digit with every segment off / on.
   localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [6:0] SEG_ON  = ~SEG_OFF;
   localparam logic [7*NUM_DIGITS-1:0] DISP_OFF = {NUM_DIGITS{SEG_OFF}};
   localparam logic [7*NUM_DIGITS-1:0] DISP_ON  = {NUM_DIGITS{SEG_ON}};

   typedef enum logic {
      ST_LAMP,
      ST_RUN
   } state_t;

   localparam state_t ST_INIT = (LAMP_CYCLES > 0) ? ST_LAMP : ST_RUN;

   state_t                    state_reg, state_next;
   logic [4*NUM_DIGITS-1:0]   val_reg;
   logic [BLINK_W-1:0]        blink_cnt_reg, blink_cnt_next;
   logic                      blink_phase_reg, blink_phase_next;
   logic [LAMP_W-1:0]         lamp_cnt_reg, lamp_cnt_next;
   logic [7*NUM_DIGITS-1:0]   disp_reg, disp_next;
   logic [7*NUM_DIGITS-1:0]   run_disp;

   // upper_zero[d] = nibbles d..NUM_DIGITS-1 are all zero.
   logic [NUM_DIGITS:0]       upper_zero;

   // Hex decode to the physical segment levels (polarity already applied).
   function automatic logic [6:0] seg_encode(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'h0: pat = 7'b0111111;
         4'h1: pat = 7'b0000110;
         4'h2: pat = 7'b1011011;
         4'h3: pat = 7'b1001111;
         4'h4: pat = 7'b1100110;
         4'h5: pat = 7'b1101101;
         4'h6: pat = 7'b1111101;
         4'h7: pat = 7'b0000111;
         4'h8: pat = 7'b1111111;
         4'h9: pat = 7'b1100111;
         4'hA: pat = 7'b1110111;
         4'hB: pat = 7'b1111100;
         4'hC: pat = 7'b0111001;
         4'hD: pat = 7'b1011110;
         4'hE: pat = 7'b1111001;
         default: pat = 7'b1110001;
      endcase
      return (ACTIVE_LOW != 0) ? ~pat : pat;
   endfunction

   assign upper_zero[NUM_DIGITS] = 1'b1;

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         logic [3:0] nib;
         logic       lzb_blank;
         logic       blink_blank;

         assign nib            = val_reg[4*gi +: 4];
         assign upper_zero[gi] = (nib == 4'h0) && upper_zero[gi+1];
         // Digit 0 is exempt so that a zero value still shows one "0".
         assign lzb_blank      = (gi != 0) && lzb_en_i && upper_zero[gi];
         assign blink_blank    = blink_mask_i[gi] && !blink_phase_reg;

         assign run_disp[7*gi +: 7] = (blank_i || blink_blank || lzb_blank)
                                      ? SEG_OFF : seg_encode(nib);
      end
   endgenerate

   always_comb begin
      state_next       = state_reg;
      lamp_cnt_next    = lamp_cnt_reg;
      disp_next        = run_disp;
      blink_cnt_next   = blink_cnt_reg + BLINK_W'(1);
      blink_phase_next = blink_phase_reg;

      // Free-running blink divider; phase flips on the wrap edge.
      if (blink_cnt_reg == BLINK_W'(BLINK_DIV - 1)) begin
         blink_cnt_next   = '0;
         blink_phase_next = ~blink_phase_reg;
      end

      case (state_reg)
         ST_LAMP: begin
            disp_next     = DISP_ON;
            lamp_cnt_next = lamp_cnt_reg + LAMP_W'(1);
            if (lamp_cnt_reg == LAMP_W'(LAMP_CYCLES - 1)) begin
               state_next = ST_RUN;
            end
         end
         default: begin
            state_next = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg       <= ST_INIT;
         lamp_cnt_reg    <= '0;
         blink_cnt_reg   <= '0;
         blink_phase_reg <= 1'b1;
         disp_reg        <= DISP_OFF;
      end else begin
         state_reg       <= state_next;
         lamp_cnt_reg    <= lamp_cnt_next;
         blink_cnt_reg   <= blink_cnt_next;
         blink_phase_reg <= blink_phase_next;
         disp_reg        <= disp_next;
      end
   end

   // Value capture is independent of state, so a load during the lamp test
   // is kept and shown once RUN starts.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         val_reg <= '0;
      end else if (load_i) begin
         val_reg <= value_i;
      end
   end

   assign disp_o        = disp_reg;
   assign lamp_o        = (state_reg == ST_LAMP);
   assign blink_phase_o = blink_phase_reg;

endmodule

// File: tb/tb_seg_display_ctrl.sv
module tb_seg_display_ctrl;

   localparam int N = 5;

   // Active-low digit patterns.
   localparam logic [6:0] S0 = 7'h40;
   localparam logic [6:0] S1 = 7'h79;
   localparam logic [6:0] S2 = 7'h24;
   localparam logic [6:0] S3 = 7'h30;
   localparam logic [6:0] S4 = 7'h19;
   localparam logic [6:0] S5 = 7'h12;
   localparam logic [6:0] SA = 7'h08;
   localparam logic [6:0] SF = 7'h0E;
   localparam logic [6:0] SB = 7'h7F;

   localparam logic [34:0] ALL_OFF  = {5{SB}};
   localparam logic [34:0] ALL_ON   = 35'h0;
   localparam logic [34:0] ZEROS    = {S0, S0, S0, S0, S0};
   localparam logic [34:0] V1A2F3   = {S1, SA, S2, SF, S3};
   localparam logic [34:0] LZB405   = {SB, SB, S4, S0, S5};
   localparam logic [34:0] LZB0     = {SB, SB, SB, SB, S0};
   localparam logic [34:0] VAL5     = {S0, S0, S0, S0, S5};
   localparam logic [34:0] VAL5_BLK = {S0, S0, S0, S0, SB};
   localparam logic [34:0] V12345   = {S1, S2, S3, S4, S5};

   logic          clk = 1'b0;
   logic          rst;
   logic          load;
   logic [19:0]   value;
   logic          lzb_en;
   logic          blank;
   logic [4:0]    blink_mask;
   logic [34:0]   disp;
   logic          lamp;
   logic          blink_phase;

   int tests  = 0;
   int fails  = 0;
   int cyc    = 0;
   int rel_cyc = 0;

   typedef struct {
      int          cyc;
      logic [34:0] disp;
      logic        lamp;
      logic        phase;
   } exp_t;

   exp_t  exp_q[$];
   string nm_q[$];
   exp_t  mon_e;
   string mon_nm;

   seg_display_ctrl #(
      .NUM_DIGITS  (5),
      .ACTIVE_LOW  (1),
      .BLINK_DIV   (4),
      .LAMP_CYCLES (3)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .load_i        (load),
      .value_i       (value),
      .lzb_en_i      (lzb_en),
      .blank_i       (blank),
      .blink_mask_i  (blink_mask),
      .disp_o        (disp),
      .lamp_o        (lamp),
      .blink_phase_o (blink_phase)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Blink phase after k edges since reset release (BLINK_DIV = 4, starts at 1).
   function automatic logic ph(input int k);
      return ((k / 4) % 2) == 0;
   endfunction

   task automatic check(input string nm, input logic [34:0] act, input logic [34:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
      end else begin
         $display("ok   %s cyc=%0d val=%h", nm, cyc, act);
      end
   endtask

   task automatic push(input int rel_at, input logic [34:0] d, input logic l, input string nm);
      exp_t e;
      e.cyc   = cyc + rel_at;
      e.disp  = d;
      e.lamp  = l;
      e.phase = ph(e.cyc - rel_cyc);
      exp_q.push_back(e);
      nm_q.push_back(nm);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares the display against the scoreboard entry due this cycle.
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         mon_e  = exp_q.pop_front();
         mon_nm = nm_q.pop_front();
         if (mon_e.cyc != cyc) begin
            check({mon_nm, "_late"}, 35'(cyc), 35'(mon_e.cyc));
         end else begin
            check({mon_nm, "_disp"}, disp, mon_e.disp);
            check({mon_nm, "_lamp"}, 35'(lamp), 35'(mon_e.lamp));
            check({mon_nm, "_phase"}, 35'(blink_phase), 35'(mon_e.phase));
         end
      end
   end

   task automatic lamp_sequence();
      push(1, ALL_ON, 1'b1, "lamp1");
      push(2, ALL_ON, 1'b1, "lamp2");
      push(3, ALL_ON, 1'b0, "lamp_end");
      push(4, ZEROS,  1'b0, "run_zero");
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; value = '0; lzb_en = 1'b0; blank = 1'b0; blink_mask = '0;
      repeat (3) tick();

      // Reset release and lamp test.
      rst = 1'b0;
      rel_cyc = cyc;
      push(0, ALL_OFF, 1'b1, "rst_state");
      lamp_sequence();
      repeat (4) tick();

      // Plain load, two-edge latency.
      value = 20'h1A2F3; load = 1'b1;
      push(2, V1A2F3, 1'b0, "load_1a2f3");
      tick(); load = 1'b0; tick(); tick();

      // Leading-zero blanking.
      lzb_en = 1'b1; value = 20'h00405; load = 1'b1;
      push(2, LZB405, 1'b0, "lzb_00405");
      tick(); load = 1'b0; tick(); tick();

      value = 20'h00000; load = 1'b1;
      push(2, LZB0, 1'b0, "lzb_zero");
      tick(); load = 1'b0; tick(); tick();

      lzb_en = 1'b0; value = 20'h00005; load = 1'b1;
      push(2, VAL5, 1'b0, "val_5");
      tick(); load = 1'b0; tick(); tick();

      // Blink on digit 0: display follows the phase held before each edge.
      blink_mask = 5'b00001;
      for (int i = 1; i <= 12; i++) begin
         push(i, ph(cyc + i - 1 - rel_cyc) ? VAL5 : VAL5_BLK, 1'b0, "blink");
      end
      repeat (12) tick();
      blink_mask = '0;
      push(1, VAL5, 1'b0, "blink_off");
      repeat (3) tick();

      // Load under global blank: stored but hidden until blank drops.
      blank = 1'b1; value = 20'h12345; load = 1'b1;
      push(1, ALL_OFF, 1'b0, "blank_on");
      push(2, ALL_OFF, 1'b0, "blank_hidden");
      tick(); load = 1'b0; tick();
      blank = 1'b0;
      push(1, V12345, 1'b0, "unblank");
      repeat (3) tick();

      // Asynchronous reset mid-RUN takes effect without a clock edge.
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_disp", disp, ALL_OFF);
      check("async_rst_lamp", 35'(lamp), 35'(1'b1));
      check("async_rst_phase", 35'(blink_phase), 35'(1'b1));
      tick(); tick();
      rst = 1'b0;
      rel_cyc = cyc;
      lamp_sequence();
      repeat (6) tick();

      for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick();
      if (exp_q.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
